// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor (a - b mod 2^WIDTH) with final borrow
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : begin a subtraction (sampled only while idle)
//   a, b   : minuend / subtrahend, captured on the accepted start
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, diff/c_out valid
//   diff   : result a - b modulo 2^WIDTH, held until the next done
//   c_out  : final borrow (a < b unsigned)
//
// Optional build macro SERIAL_SUB_SAT_EN: saturating unsigned subtract
// (diff forced to zero when the final borrow is set).

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             c_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 result bits produced so far; the last bit is merged
    // in straight into diff_q on the final shift cycle.
    logic [WIDTH-2:0] d_sr;
    logic             bw_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             c_out_q;

    logic             last_bit;
    logic             hs1_d;
    logic             hs1_bo;
    logic             d_bit;
    logic             hs2_bo;
    logic             bw_next;

    // Full-subtractor cell: two half-subtractors plus the registered borrow.
    always_comb begin
        hs1_d   = a_sr[0] ^ b_sr[0];
        hs1_bo  = ~a_sr[0] & b_sr[0];
        d_bit   = hs1_d ^ bw_q;
        hs2_bo  = ~hs1_d & bw_q;
        bw_next = hs1_bo | hs2_bo;
    end

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            d_sr    <= '0;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            c_out_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        bw_q  <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    d_sr  <= (WIDTH-1)'({d_bit, d_sr} >> 1);
                    bw_q  <= bw_next;
                    cnt_q <= cnt_q + CW'(1);
                    // diff/c_out only change here, on entry to DONE.
                    if (last_bit) begin
`ifdef SERIAL_SUB_SAT_EN
                        diff_q <= bw_next ? '0 : {d_bit, d_sr};
`else
                        diff_q <= {d_bit, d_sr};
`endif
                        c_out_q <= bw_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_q == S_SHIFT);
    assign done  = (state_q == S_DONE);
    assign diff  = diff_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)

module tb_serial_subtractor;

    localparam int W = 8;
`ifdef SERIAL_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         c_out;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle", nm, act, exp);
    endtask

    // Reference model in terms of cycle numbers: a start accepted in cycle k
    // yields done in cycle k+W+1, busy in k+1..k+W, next accept from k+W+2.
    int           cyc       = 0;
    int           done_cyc  = -1;
    int           next_free = 0;
    int           accepted  = 0;
    logic [W-1:0] pend_diff = '0;
    logic         pend_bw   = 1'b0;
    logic [W-1:0] held_diff = '0;
    logic         held_bw   = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            done_cyc  = -1;
            next_free = cyc + 1;
        end else if (start && cyc >= next_free) begin
            done_cyc  = cyc + W + 1;
            next_free = cyc + W + 2;
            pend_diff = W'(a - b);
            pend_bw   = (a < b);
            accepted++;
        end
        cyc++;
    end

    always @(negedge clk) begin
        logic exp_busy;
        if (!rst_n) begin
            done_cyc  = -1;
            held_diff = '0;
            held_bw   = 1'b0;
        end else if (cyc == done_cyc) begin
            held_diff = (SAT && pend_bw) ? '0 : pend_diff;
            held_bw   = pend_bw;
        end
        exp_busy = (done_cyc >= 0) && (cyc >= done_cyc - W) && (cyc < done_cyc);
        check("busy", busy, exp_busy);
        check("done", done, (cyc == done_cyc));
        check("diff", diff, held_diff);
        check("c_out", c_out, held_bw);
    end

    // Directed op with hand-computed expectations: latency, busy length, result.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [W-1:0] ed, input logic ec, input string nm);
        int k;
        int nbusy;
        bit got;
        @(posedge clk); #1;
        a = xa; b = xb; start = 1'b1; k = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0; nbusy = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) got = 1;
        end
        check({nm, " done_seen"}, got, 1);
        if (got) begin
            check({nm, " latency"}, cyc - k, 9);
            check({nm, " busy_cycles"}, nbusy, 8);
            check({nm, " diff"}, diff, ed);
            check({nm, " c_out"}, c_out, ec);
        end
    endtask

    initial begin
        int ndone;
        int acc0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        @(posedge clk); #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset diff", diff, 0);
        check("reset c_out", c_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(8'h5A, 8'h23, 8'h37, 1'b0, "sub_5a_23");
        run_op(8'h10, 8'h20, SAT ? 8'h00 : 8'hF0, 1'b1, "sub_10_20");
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "sub_ff_ff");
        run_op(8'h00, 8'h01, SAT ? 8'h00 : 8'hFF, 1'b1, "sub_00_01");
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, "sub_80_01_prime");

        // Re-pulsed start during SHIFT must be dropped.
        @(posedge clk); #1;
        a = 8'h80; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("repulse diff", diff, 8'h7F);
                check("repulse c_out", c_out, 0);
            end
        end
        check("repulse done_count", ndone, 1);

        // Reset at the 4th SHIFT cycle aborts the operation.
        @(posedge clk); #1;
        a = 8'hC3; b = 8'h15; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort diff", diff, 0);
        check("abort c_out", c_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort done_count", ndone, 0);
        run_op(8'h09, 8'h03, 8'h06, 1'b0, "sub_09_03");

        // Random operands and random start pulses every cycle; model checks all.
        acc0 = accepted;
        for (int i = 0; i < 30000 && accepted < acc0 + 1000; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? 8'hFF : 8'h00) : 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? 8'hFF : 8'h00) : 8'($urandom);
        end
        start = 1'b0;
        check("random ops accepted", (accepted - acc0 >= 1000), 1);
        repeat (12) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
